cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Run-control sequencer for the single-cycle 16-bit `mips` core. It loads a program into instruction memory through a host valid/ready stream, then resets and releases the core. It gates execution with a clock-enable, supporting free-run, pause and single-step. It stops the core on a HALT opcode (`5'b11011`) or a watchdog limit, and reports status and executed-cycle count to the host.

## Interface
Parameters:
- `ADDR_W`, 8: instruction-memory address width (matches `pc`).
- `DATA_W`, 16: instruction word width.
- `WDOG_LIMIT`, 16'hFFFF: executed-cycle limit before forced stop.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `load_start`  in  1  pulse: begin program load.
- `ld_count`  in  ADDR_W  word count, sampled with `load_start`; 0 means 256.
- `ld_valid`  in  1  load word valid.
- `ld_data`  in  DATA_W  load word.
- `ld_ready`  out  1  controller accepts a load word.
- `run`  in  1  pulse: start from reset, or resume from pause.
- `pause`  in  1  pulse: suspend execution.
- `step`  in  1  pulse: execute one instruction while paused.
- `abort`  in  1  pulse: return to IDLE from any state.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  ADDR_W  instruction-memory write address.
- `imem_wdata`  out  DATA_W  instruction-memory write data.
- `cpu_reset`  out  1  active-high reset to `mips.reset`.
- `cpu_en`  out  1  core clock-enable; the core state advances only when 1.
- `pc`  in  ADDR_W  core PC (monitor only).
- `instr`  in  DATA_W  instruction currently presented to the core.
- `busy`  out  1  high in LOAD, CPURST, RUN, PAUSED.
- `halted`  out  1  high in HALTED.
- `timeout`  out  1  HALTED was entered by the watchdog.
- `cycle_count`  out  16  executed cycles since last CPURST; saturating.

## Operation
States and outputs:
- IDLE: `cpu_reset`=1, `cpu_en`=0.
- LOAD: `cpu_reset`=1; `ld_ready`=1.
- CPURST: `cpu_reset`=1 for exactly 2 cycles; `cycle_count` cleared.
- RUN: `cpu_reset`=0.
- PAUSED: `cpu_reset`=0; `cpu_en`=0 except during a step cycle.
- HALTED: `cpu_reset`=0 (register file preserved for inspection); `cpu_en`=0.

Transitions:
- IDLE/HALTED + `load_start` → LOAD. Address counter = 0; remaining = `ld_count` (0 → 256); `timeout` cleared.
- LOAD: each `ld_valid && ld_ready` beat drives `imem_we`=1, `imem_addr`=counter, `imem_wdata`=`ld_data` combinationally, then counter++. Leaves for IDLE after the final beat; `ld_ready` is 0 from the next cycle. Address wraps 255→0 only on a 256-word load, which then terminates.
- IDLE/HALTED + `run` → CPURST → RUN.
- RUN: `cpu_en` = !(instr[15:11]==HALT), combinational. A HALT opcode gives `cpu_en`=0 in that cycle and next state HALTED; HALT is never executed.
- RUN + `pause` → PAUSED. `cpu_en` is 0 in the pause cycle itself.
- PAUSED + `step`: `cpu_en`=1 for that one cycle unless `instr` is HALT, in which case → HALTED. PAUSED + `run` → RUN with no core reset.
- Watchdog: each cycle with `cpu_en`=1 increments `cycle_count`. When the increment reaches `WDOG_LIMIT`, that cycle executes, then → HALTED with `timeout`=1. The count saturates at 16'hFFFF.
- `abort` in any state → IDLE next cycle; `cpu_en`=0 in the abort cycle.
- Priority: `abort` > HALT detect > watchdog > `pause` > `run`/`step` > `load_start`. Commands not valid in the current state are ignored; `ld_valid` outside LOAD is ignored.

## Timing
- Reset (`reset`=0 at an edge): state IDLE; `cpu_reset`=1; `cpu_en`=0; `imem_we`=0; `imem_addr`=0; `imem_wdata`=0; `ld_ready`=0; `busy`=0; `halted`=0; `timeout`=0; `cycle_count`=0. Reset during LOAD or RUN aborts immediately with the same values.
- Load throughput: 1 word/cycle with `ld_valid` held high. N words occupy N cycles in LOAD.
- `run` pulse at edge k: CPURST for cycles k+1 and k+2; RUN with `cpu_en`=1 from cycle k+3; core fetches PC 0 at k+3.
- HALT at `instr`: `halted`=1 one cycle later.
- Step granularity: exactly one core cycle per `step` pulse; pulses on consecutive cycles give consecutive steps.

## Test plan
- Load 4 words (A,B,C,D), `ld_valid` always high → `imem_we` for 4 cycles, addresses 0..3, `ld_ready` falls after word 4, state IDLE. Repeat with `ld_count`=0 → 256 writes, addresses 0..255.
- `run` → `cpu_reset` high for 2 cycles, then `cpu_en`=1. `instr`={ADDI gr1,0x11} ×3, then {HALT,11'b0} → `cycle_count`=3, `cpu_en`=0 on the HALT cycle, `halted`=1 next cycle.
- RUN, `pause` after 5 cycles → `cpu_en`=0 and `cycle_count`=5. 3 `step` pulses → `cycle_count`=8, exactly 3 `cpu_en` cycles. `run` → resumes without `cpu_reset`.
- `WDOG_LIMIT`=16 with no HALT in the stream → `cycle_count`=16, `halted`=1, `timeout`=1. Then `load_start` clears `timeout`.
- `abort` during LOAD at word 2, and separately during RUN → IDLE next cycle, `cpu_reset`=1, `ld_ready`=0.
- `reset` low mid-RUN → all outputs at reset values on the next edge; `pause` and `step` asserted together with HALT `instr` → HALTED, `cpu_en` never 1.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
// Run-control sequencer for the single-cycle 16-bit mips core. It streams a
// program into instruction memory and then holds the core in reset for two
// cycles. After that it gates the core with a clock-enable for free-run, pause
// and single-step operation. The core is stopped on a HALT opcode or when the
// executed-cycle watchdog expires.
//
// Ports
//   clk, reset            system clock; synchronous active-low reset
//   load_start, ld_count  begin a program load of ld_count words (0 = 256)
//   ld_valid/ld_data      load word stream; ld_ready accepts a word
//   run/pause/step/abort  host run-control pulses
//   imem_we/addr/wdata    instruction-memory write port
//   cpu_reset, cpu_en     core reset and clock-enable
//   pc, instr             core monitor inputs (instr drives HALT detection)
//   busy, halted, timeout status flags
//   cycle_count           executed cycles since last core reset, saturating
//
// state  | meaning
// IDLE   | core held in reset, waiting for load_start or run
// LOAD   | accepting program words into instruction memory
// CPURST | two-cycle core reset before execution starts
// RUN    | core free-running, one instruction per cycle
// PAUSED | core stopped; step executes a single instruction
// HALTED | core stopped on HALT or watchdog, register file preserved
module cpu_run_ctrl #(
    parameter int          ADDR_W     = 8,
    parameter int          DATA_W     = 16,
    parameter logic [15:0] WDOG_LIMIT = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] ld_count,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              run,
    input  logic              pause,
    input  logic              step,
    input  logic              abort,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              cpu_en,
    input  logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] instr,
    output logic              busy,
    output logic              halted,
    output logic              timeout,
    output logic [15:0]       cycle_count
);

    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_CPURST = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_PAUSED = 3'd4;
    localparam logic [2:0] S_HALTED = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic              rst_cnt_q, rst_cnt_d;
    logic [15:0]       cycle_count_q, cycle_count_d;
    logic              timeout_q, timeout_d;

    logic              is_halt;
    logic [16:0]       count_inc;
    logic [15:0]       count_sat;
    logic              wdog_hit;
    logic              ready_c;
    logic              beat;
    logic              en_c;

    // pc and the operand bits of instr are monitor-only here
    logic unused_monitor;
    assign unused_monitor = ^{pc, instr[DATA_W-6:0]};

    assign is_halt   = (instr[DATA_W-1 -: 5] == OP_HALT);
    assign count_inc = {1'b0, cycle_count_q} + 17'd1;
    assign count_sat = count_inc[16] ? 16'hFFFF : count_inc[15:0];
    // only a real increment can trip the watchdog; a saturated count cannot
    assign wdog_hit  = !count_inc[16] && (count_inc[15:0] == WDOG_LIMIT);

    // an aborted cycle must not hand-shake a word it will not write
    assign ready_c = (state_q == S_LOAD) && !abort;
    assign beat    = ready_c && ld_valid;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remain_d      = remain_q;
        rst_cnt_d     = rst_cnt_q;
        cycle_count_d = cycle_count_q;
        timeout_d     = timeout_q;
        en_c          = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_HALTED: begin
                    if (run) begin
                        state_d       = S_CPURST;
                        rst_cnt_d     = 1'b0;
                        cycle_count_d = 16'd0;
                        timeout_d     = 1'b0;
                    end else if (load_start) begin
                        state_d   = S_LOAD;
                        addr_d    = '0;
                        remain_d  = (ld_count == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                                     : {1'b0, ld_count};
                        timeout_d = 1'b0;
                    end
                end
                S_LOAD: begin
                    if (beat) begin
                        addr_d   = addr_q + 1'b1;
                        remain_d = remain_q - 1'b1;
                        if (remain_q == (ADDR_W+1)'(1)) begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_CPURST: begin
                    cycle_count_d = 16'd0;
                    if (rst_cnt_q) begin
                        state_d = S_RUN;
                    end else begin
                        rst_cnt_d = 1'b1;
                    end
                end
                S_RUN: begin
                    // HALT is detected before it executes
                    if (is_halt) begin
                        state_d = S_HALTED;
                    end else if (pause) begin
                        state_d = S_PAUSED;
                    end else begin
                        en_c          = 1'b1;
                        cycle_count_d = count_sat;
                        if (wdog_hit) begin
                            state_d   = S_HALTED;
                            timeout_d = 1'b1;
                        end
                    end
                end
                S_PAUSED: begin
                    if (step) begin
                        if (is_halt) begin
                            state_d = S_HALTED;
                        end else begin
                            en_c          = 1'b1;
                            cycle_count_d = count_sat;
                            if (wdog_hit) begin
                                state_d   = S_HALTED;
                                timeout_d = 1'b1;
                            end else if (run) begin
                                state_d = S_RUN;
                            end
                        end
                    end else if (run) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            remain_q      <= '0;
            rst_cnt_q     <= 1'b0;
            cycle_count_q <= 16'd0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remain_q      <= remain_d;
            rst_cnt_q     <= rst_cnt_d;
            cycle_count_q <= cycle_count_d;
            timeout_q     <= timeout_d;
        end
    end

    assign ld_ready    = ready_c;
    assign imem_we     = beat;
    assign imem_addr   = beat ? addr_q : '0;
    assign imem_wdata  = beat ? ld_data : '0;
    assign cpu_en      = en_c;
    assign cpu_reset   = (state_q == S_IDLE) || (state_q == S_LOAD) ||
                         (state_q == S_CPURST);
    assign busy        = (state_q == S_LOAD) || (state_q == S_CPURST) ||
                         (state_q == S_RUN)  || (state_q == S_PAUSED);
    assign halted      = (state_q == S_HALTED);
    assign timeout     = timeout_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

    localparam int          ADDR_W = 8;
    localparam int          DATA_W = 16;
    localparam logic [15:0] WD     = 16'd16;
    localparam logic [15:0] HALT_W = 16'hD800;

    logic              clk;
    logic              reset;
    logic              load_start;
    logic [ADDR_W-1:0] ld_count;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              run, pause, step, abort;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_reset, cpu_en;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic              busy, halted, timeout;
    logic [15:0]       cycle_count;

    cpu_run_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WDOG_LIMIT(WD)) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .ld_count(ld_count),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .run(run), .pause(pause), .step(step), .abort(abort),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .cpu_en(cpu_en), .pc(pc), .instr(instr),
        .busy(busy), .halted(halted), .timeout(timeout), .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {A_EXEC, A_PAUSE, A_IDLE, A_STEP, A_RESUME, A_HALT, A_PSH, A_STEPHALT} act_t;

    int          checks   = 0;
    int          failures = 0;
    int          en_cnt   = 0;
    logic [7:0]  wq_addr[$];
    logic [15:0] wq_data[$];
    logic [15:0] exp_d[$];
    logic [15:0] words[4];
    act_t        scr[$];
    bit          exp_timeout = 1'b0;
    int          sent, guard, bad, n_exec, n_step, n_tail, r;

    // monitor of enable pulses and memory writes, sampled mid-cycle
    always @(negedge clk) begin
        if (cpu_en === 1'b1) en_cnt++;
        if (imem_we === 1'b1) begin
            wq_addr.push_back(imem_addr);
            wq_data.push_back(imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15:11] == 5'b11011) w[15] = 1'b0;
        return w;
    endfunction

    task automatic clear_inputs();
        load_start = 0; run = 0; pause = 0; step = 0; abort = 0;
        ld_valid = 0; ld_data = '0; instr = rand_instr();
    endtask

    // run pulse, then two cycles of core reset; returns in the first RUN cycle
    task automatic start_run(input string tag);
        run = 1'b1;
        tick();
        run = 1'b0;
        #1;
        chk({tag, ".rst1"}, cpu_reset, 1'b1);
        chk({tag, ".en_rst1"}, cpu_en, 1'b0);
        chk({tag, ".busy_rst"}, busy, 1'b1);
        tick();
        #1;
        chk({tag, ".rst2"}, cpu_reset, 1'b1);
        chk({tag, ".cnt_clr"}, cycle_count, 16'd0);
        tick();
    endtask

    // one-word load, used to clear a sticky timeout
    task automatic load_one(input string tag);
        load_start = 1'b1;
        ld_count   = 8'd1;
        tick();
        load_start = 1'b0;
        ld_valid   = 1'b1;
        ld_data    = 16'($urandom);
        #1;
        chk({tag, ".timeout_clr"}, timeout, 1'b0);
        chk({tag, ".we"}, imem_we, 1'b1);
        tick();
        ld_valid = 1'b0;
        #1;
        chk({tag, ".idle"}, busy, 1'b0);
        exp_timeout = 1'b0;
    endtask

    // plays the action script from the first RUN cycle; model counts executed cycles
    task automatic play(input string tag);
        int  cnt;
        int  en0;
        bit  wd;
        bit  ended;
        bit  exp_en;
        act_t a;
        cnt = 0; wd = 0; ended = 0; en0 = en_cnt;
        for (int i = 0; i < scr.size(); i++) begin
            a = scr[i];
            clear_inputs();
            ld_valid = 1'($urandom);
            ld_data  = 16'($urandom);
            exp_en   = 1'b0;
            case (a)
                A_EXEC:     begin step = 1'($urandom); exp_en = 1'b1; end
                A_PAUSE:    pause = 1'b1;
                A_IDLE:     begin
                                if ($urandom_range(0, 2) == 0) instr = HALT_W;
                                pause = 1'($urandom);
                            end
                A_STEP:     begin step = 1'b1; exp_en = 1'b1; end
                A_RESUME:   run = 1'b1;
                A_HALT:     begin instr = HALT_W; pause = 1'($urandom); end
                A_PSH:      begin instr = HALT_W; pause = 1'b1; step = 1'b1; end
                A_STEPHALT: begin instr = HALT_W; step = 1'b1; end
                default:    ;
            endcase
            #1;
            chk({tag, ".en"}, cpu_en, exp_en);
            chk({tag, ".cnt"}, cycle_count, cnt);
            chk({tag, ".cpurst"}, cpu_reset, 1'b0);
            chk({tag, ".we_ign"}, imem_we, 1'b0);
            tick();
            if (exp_en) begin
                cnt++;
                if (cnt == int'(WD)) begin wd = 1'b1; ended = 1'b1; end
            end
            if (a == A_HALT || a == A_PSH || a == A_STEPHALT) ended = 1'b1;
            if (ended) break;
        end
        clear_inputs();
        #1;
        if (wd) exp_timeout = 1'b1;
        chk({tag, ".halted"}, halted, ended);
        chk({tag, ".busy_end"}, busy, !ended);
        chk({tag, ".timeout"}, timeout, exp_timeout);
        chk({tag, ".cnt_end"}, cycle_count, cnt);
        chk({tag, ".en_end"}, cpu_en, 1'b0);
        chk({tag, ".en_pulses"}, en_cnt - en0, cnt);
    endtask

    task automatic push_n(input act_t a, input int n);
        for (int k = 0; k < n; k++) scr.push_back(a);
    endtask

    initial begin
        pc = '0;
        ld_count = '0;
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        #1;
        chk("rst.cpu_reset", cpu_reset, 1'b1);
        chk("rst.cpu_en", cpu_en, 1'b0);
        chk("rst.we", imem_we, 1'b0);
        chk("rst.addr", imem_addr, 8'd0);
        chk("rst.wdata", imem_wdata, 16'd0);
        chk("rst.ready", ld_ready, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.halted", halted, 1'b0);
        chk("rst.timeout", timeout, 1'b0);
        chk("rst.cnt", cycle_count, 16'd0);
        reset = 1'b1;

        // pause/step/ld_valid are ignored in IDLE
        step = 1'b1; pause = 1'b1; ld_valid = 1'b1;
        #1;
        chk("idle.we_ign", imem_we, 1'b0);
        tick();
        clear_inputs();
        #1;
        chk("idle.stay", busy, 1'b0);

        // 4-word load, valid held high
        foreach (words[i]) words[i] = 16'($urandom);
        wq_addr.delete(); wq_data.delete();
        load_start = 1'b1;
        ld_count   = 8'd4;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_data  = words[i];
            #1;
            chk("ld4.ready", ld_ready, 1'b1);
            chk("ld4.we", imem_we, 1'b1);
            chk("ld4.addr", imem_addr, i);
            chk("ld4.data", imem_wdata, words[i]);
            chk("ld4.cpurst", cpu_reset, 1'b1);
            tick();
        end
        ld_data = 16'($urandom);
        #1;
        chk("ld4.ready_fall", ld_ready, 1'b0);
        chk("ld4.we_off", imem_we, 1'b0);
        chk("ld4.idle", busy, 1'b0);
        chk("ld4.nwrites", wq_addr.size(), 4);
        ld_valid = 1'b0;

        // 256-word load with random valid gaps
        wq_addr.delete(); wq_data.delete(); exp_d.delete();
        load_start = 1'b1;
        ld_count   = 8'd0;
        tick();
        load_start = 1'b0;
        sent = 0; guard = 0;
        while (sent < 256 && guard < 3000) begin
            ld_valid = ($urandom_range(0, 3) != 0);
            ld_data  = 16'($urandom);
            if (ld_valid) begin
                exp_d.push_back(ld_data);
                sent++;
            end
            tick();
            guard++;
        end
        ld_valid = 1'b1;
        #1;
        chk("ld256.ready_fall", ld_ready, 1'b0);
        chk("ld256.we_off", imem_we, 1'b0);
        ld_valid = 1'b0;
        chk("ld256.nwrites", wq_addr.size(), 256);
        bad = 0;
        for (int i = 0; i < wq_addr.size() && i < 256; i++) begin
            if (wq_addr[i] !== 8'(i) || wq_data[i] !== exp_d[i]) bad++;
        end
        chk("ld256.content", bad, 0);

        // 3 instructions then HALT
        start_run("halt3");
        scr.delete(); push_n(A_EXEC, 3); push_n(A_HALT, 1);
        play("halt3");

        // pause after 5, three steps (two back-to-back), resume, HALT
        start_run("pause");
        scr.delete();
        push_n(A_EXEC, 5); push_n(A_PAUSE, 1); push_n(A_STEP, 2); push_n(A_IDLE, 1);
        push_n(A_STEP, 1); push_n(A_RESUME, 1); push_n(A_EXEC, 2); push_n(A_HALT, 1);
        play("pause");

        // watchdog expiry, then load_start clears timeout
        start_run("wdog");
        scr.delete(); push_n(A_EXEC, 20); push_n(A_HALT, 1);
        play("wdog");
        load_one("wdog_clr");

        // pause and step together with HALT
        start_run("psh");
        scr.delete(); push_n(A_EXEC, 2); push_n(A_PSH, 1);
        play("psh");

        // randomized trials
        for (int t = 0; t < 12; t++) begin
            if (exp_timeout) load_one("rnd_clr");
            scr.delete();
            n_exec = $urandom_range(0, 8);
            push_n(A_EXEC, n_exec);
            r = $urandom_range(0, 3);
            if (r == 0) begin
                push_n(($urandom_range(0, 1) == 0) ? A_HALT : A_PSH, 1);
            end else begin
                push_n(A_PAUSE, 1);
                n_step = $urandom_range(0, 5);
                for (int k = 0; k < n_step; k++) begin
                    push_n(A_IDLE, $urandom_range(0, 2));
                    push_n(A_STEP, 1);
                end
                push_n(A_IDLE, $urandom_range(0, 2));
                if (r == 1) begin
                    push_n(A_STEPHALT, 1);
                end else begin
                    push_n(A_RESUME, 1);
                    n_tail = $urandom_range(0, 10);
                    push_n(A_EXEC, n_tail);
                    push_n(A_HALT, 1);
                end
            end
            start_run("rnd");
            play("rnd");
        end

        // abort during RUN
        start_run("abrun");
        instr = rand_instr();
        tick(); tick(); tick();
        abort = 1'b1;
        #1;
        chk("abrun.en", cpu_en, 1'b0);
        tick();
        abort = 1'b0;
        #1;
        chk("abrun.cpurst", cpu_reset, 1'b1);
        chk("abrun.busy", busy, 1'b0);
        chk("abrun.halted", halted, 1'b0);
        chk("abrun.ready", ld_ready, 1'b0);

        // abort during LOAD at word 2
        load_start = 1'b1;
        ld_count   = 8'd4;
        tick();
        load_start = 1'b0;
        ld_valid   = 1'b1;
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        chk("abld.ready", ld_ready, 1'b0);
        chk("abld.we", imem_we, 1'b0);
        chk("abld.cpurst", cpu_reset, 1'b1);
        chk("abld.busy", busy, 1'b0);
        ld_valid = 1'b0;

        // reset mid-RUN
        start_run("rstrun");
        instr = rand_instr();
        tick(); tick(); tick();
        reset    = 1'b0;
        ld_valid = 1'b1;
        tick();
        #1;
        chk("rstrun.cpu_reset", cpu_reset, 1'b1);
        chk("rstrun.cpu_en", cpu_en, 1'b0);
        chk("rstrun.we", imem_we, 1'b0);
        chk("rstrun.addr", imem_addr, 8'd0);
        chk("rstrun.ready", ld_ready, 1'b0);
        chk("rstrun.busy", busy, 1'b0);
        chk("rstrun.halted", halted, 1'b0);
        chk("rstrun.timeout", timeout, 1'b0);
        chk("rstrun.cnt", cycle_count, 16'd0);
        reset    = 1'b1;
        ld_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
